// File: rtl/rom_stream_reader.sv
// rom_stream_reader: fetches a burst of consecutive words from a synchronous
// block ROM and presents them on a valid/ready stream. Throughput is one word
// per clock. A 2-entry buffer covers the one-clock ROM latency when the sink
// applies backpressure.
module rom_stream_reader #(
  parameter int unsigned W = 8,
  parameter int unsigned L = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [$clog2(L)-1:0]   start_addr_i,
  input  logic [$clog2(L):0]     count_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [$clog2(L)-1:0]   rom_addr_o,
  input  logic [W-1:0]           rom_data_i,
  output logic [W-1:0]           out_data_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   out_last_o
);

  localparam int unsigned AW = $clog2(L);
  localparam int unsigned CW = $clog2(L) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic [CW-1:0]   remaining_q, remaining_d;
  logic            pend_q, pend_d;
  logic            pend_last_q, pend_last_d;
  logic            done_q, done_d;
  logic [W-1:0]    mem_data_q [2];
  logic [W-1:0]    mem_data_d [2];
  logic            mem_last_q [2];
  logic            mem_last_d [2];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      occ_q, occ_d;

  logic            pop;
  logic            push;
  logic            issue;
  logic [2:0]      credit;

  // Next-state: burst control, ROM issue with credit check, output FIFO.
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    remaining_d = remaining_q;
    pend_d      = 1'b0;
    pend_last_d = 1'b0;
    done_d      = 1'b0;
    mem_data_d  = mem_data_q;
    mem_last_d  = mem_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;

    pop    = (occ_q != 2'd0) && out_ready_i;
    push   = pend_q;
    // Entries held plus the word in flight, after this clock's pop, must leave room.
    credit = 3'(occ_q) + 3'(pend_q) - 3'(pop);
    issue  = (state_q == RUN) && (remaining_q != '0) && (credit < 3'd2);

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          rom_addr_d  = start_addr_i;
          remaining_d = count_i;
          if (count_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (issue) begin
          rom_addr_d  = (rom_addr_q == AW'(L - 1)) ? '0 : rom_addr_q + AW'(1);
          remaining_d = remaining_q - CW'(1);
          pend_d      = 1'b1;
          pend_last_d = (remaining_q == CW'(1));
        end
        if (pop && mem_last_q[rd_ptr_q]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pop clears the head's last flag so a drained slot never shows a stale marker.
    if (pop) begin
      mem_last_d[rd_ptr_q] = 1'b0;
      rd_ptr_d             = ~rd_ptr_q;
    end
    if (push) begin
      mem_data_d[wr_ptr_q] = rom_data_i;
      mem_last_d[wr_ptr_q] = pend_last_q;
      wr_ptr_d             = ~wr_ptr_q;
    end
    occ_d = occ_q + 2'(push) - 2'(pop);
  end

  // State register with synchronous reset; reset aborts any burst in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      rom_addr_q    <= '0;
      remaining_q   <= '0;
      pend_q        <= 1'b0;
      pend_last_q   <= 1'b0;
      done_q        <= 1'b0;
      mem_data_q[0] <= '0;
      mem_data_q[1] <= '0;
      mem_last_q[0] <= 1'b0;
      mem_last_q[1] <= 1'b0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      occ_q         <= 2'd0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      remaining_q <= remaining_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      done_q      <= done_d;
      mem_data_q  <= mem_data_d;
      mem_last_q  <= mem_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
    end
  end

  assign busy_o      = (state_q == RUN);
  assign done_o      = done_q;
  assign rom_addr_o  = rom_addr_q;
  assign out_data_o  = mem_data_q[rd_ptr_q];
  assign out_valid_o = (occ_q != 2'd0);
  assign out_last_o  = mem_last_q[rd_ptr_q];

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: directed bursts against an attached ROM model,
// a queue-based expectation model checked every cycle, and literal timing pins.
module tb_rom_stream_reader;

  localparam int W  = 8;
  localparam int L  = 32;
  localparam int AW = 5;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic [AW-1:0] rom_addr;
  logic [W-1:0]  rom_data;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  always #5 clk = ~clk;

  rom_stream_reader #(.W(W), .L(L)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .start_addr_i (start_addr),
    .count_i      (count),
    .busy_o       (busy),
    .done_o       (done),
    .rom_addr_o   (rom_addr),
    .rom_data_i   (rom_data),
    .out_data_o   (out_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_last_o   (out_last)
  );

  // Synchronous ROM: rom[i] = i + 0x10, data one clock after the address edge.
  logic [W-1:0] rom [L];
  initial for (int i = 0; i < L; i++) rom[i] = 8'(i + 16);
  always @(posedge clk) rom_data <= rom[rom_addr];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- expectation model ----------------
  typedef struct {
    logic [W-1:0] d;
    bit           last;
  } exp_t;

  exp_t         q[$];
  bit           m_busy     = 1'b0;
  bit           m_done     = 1'b0;
  bit           after_rst  = 1'b0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_data  = '0;

  always @(negedge clk) begin
    bit   old_busy;
    exp_t e;
    if (after_rst) begin
      check("rst_valid", int'(out_valid), 0);
      check("rst_last",  int'(out_last),  0);
      check("rst_data",  int'(out_data),  0);
      check("rst_busy",  int'(busy),      0);
      check("rst_done",  int'(done),      0);
      check("rst_addr",  int'(rom_addr),  0);
    end else begin
      check("done", int'(done), int'(m_done));
      check("busy", int'(busy), int'(m_busy));
      if (prev_stall) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data",  int'(out_data),  int'(prev_data));
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          check("data", int'(out_data), int'(q[0].d));
          check("last", int'(out_last), int'(q[0].last));
        end
      end
    end
    // Advance the model to the state after the coming edge.
    if (rst) begin
      q.delete();
      m_busy     = 1'b0;
      m_done     = 1'b0;
      after_rst  = 1'b1;
      prev_stall = 1'b0;
    end else begin
      after_rst = 1'b0;
      old_busy  = m_busy;
      m_done    = 1'b0;
      if (out_valid && out_ready && q.size() > 0) begin
        if (q[0].last) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
        void'(q.pop_front());
      end
      if (start && !old_busy) begin
        if (count == '0) begin
          m_done = 1'b1;
        end else begin
          for (int k = 0; k < int'(count); k++) begin
            e.d    = 8'(((int'(start_addr) + k) % L) + 16);
            e.last = (k == int'(count) - 1);
            q.push_back(e);
          end
          m_busy = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [W-1:0] got[$];
  bit           pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  function automatic int gw(input int k);
    return (k < got.size()) ? int'(got[k]) : -1;
  endfunction

  // Clock forward collecting handshaken words until done or budget expiry.
  task automatic collect(input int budget, input bit rnd);
    got.delete();
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (rnd) out_ready = (c <= 4) ? pat[c-1] : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (out_valid && out_ready) got.push_back(out_data);
      if (done) return;
    end
    check("collect_timeout", 0, 1);
  endtask

  task automatic begin_burst(input int a, input int n);
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = AW'(a);
    count      = CW'(n);
  endtask

  // ---------------- directed tests ----------------
  int v_exp [7];
  int d_exp [7];
  int l_exp [7];
  int b_exp [7];
  int n_exp [7];

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    count      = '0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy",  int'(busy),      0);
    check("reset_valid", int'(out_valid), 0);
    check("reset_addr",  int'(rom_addr),  0);

    // 1: addr 4, count 3, ready 1: words in clks 3..5, done clk 6, busy clks 1..5.
    v_exp = '{0, 0, 0, 1, 1, 1, 0};
    d_exp = '{0, 0, 0, 'h14, 'h15, 'h16, 0};
    l_exp = '{0, 0, 0, 0, 0, 1, 0};
    b_exp = '{0, 1, 1, 1, 1, 1, 0};
    n_exp = '{0, 0, 0, 0, 0, 0, 1};
    begin_burst(4, 3);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check($sformatf("t1_valid_c%0d", c), int'(out_valid), v_exp[c]);
      check($sformatf("t1_last_c%0d",  c), int'(out_last),  l_exp[c]);
      check($sformatf("t1_busy_c%0d",  c), int'(busy),      b_exp[c]);
      check($sformatf("t1_done_c%0d",  c), int'(done),      n_exp[c]);
      if (v_exp[c] != 0) check($sformatf("t1_data_c%0d", c), int'(out_data), d_exp[c]);
    end

    // 2: wrap from 30 through 0.
    begin_burst(30, 4);
    collect(40, 1'b0);
    check("t2_n",  got.size(), 4);
    check("t2_w0", gw(0), 'h2E);
    check("t2_w1", gw(1), 'h2F);
    check("t2_w2", gw(2), 'h10);
    check("t2_w3", gw(3), 'h11);
    check("t2_addr", int'(rom_addr), 2);

    // 3: backpressure with ready 1,0,0,1 then random.
    begin_burst(12, 8);
    collect(200, 1'b1);
    out_ready = 1'b1;
    check("t3_n", got.size(), 8);
    for (int k = 0; k < 8; k++) check($sformatf("t3_w%0d", k), gw(k), 'h1C + k);

    // 4: zero-length burst: done next clock only, no stream, never busy.
    begin_burst(7, 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("t4_done_c1",  int'(done),      1);
    check("t4_busy_c1",  int'(busy),      0);
    check("t4_valid_c1", int'(out_valid), 0);
    repeat (3) begin
      @(negedge clk);
      check("t4_done_after",  int'(done),      0);
      check("t4_valid_after", int'(out_valid), 0);
      check("t4_busy_after",  int'(busy),      0);
    end

    // 5: start mid-burst ignored; start in done clock accepted.
    begin_burst(0, 3);
    got.delete();
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 2) begin start = 1'b1; start_addr = AW'(20); count = CW'(5); end
      if (c == 6) begin start = 1'b1; start_addr = AW'(16); count = CW'(2); end
      @(negedge clk);
      if (out_valid && out_ready) got.push_back(out_data);
      if (c == 6)  check("t5_done_c6",  int'(done), 1);
      if (c == 9)  check("t5_valid_c9", int'(out_valid), 1);
      if (c == 11) check("t5_done_c11", int'(done), 1);
    end
    check("t5_n",  got.size(), 5);
    check("t5_w0", gw(0), 'h10);
    check("t5_w2", gw(2), 'h12);
    check("t5_w3", gw(3), 'h20);
    check("t5_w4", gw(4), 'h21);

    // 6: reset after two words; then a fresh burst.
    begin_burst(2, 6);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      rst   = (c == 5);
      @(negedge clk);
      if (c == 4) check("t6_w1_c4", int'(out_data), 'h13);
    end
    check("t6_valid", int'(out_valid), 0);
    check("t6_busy",  int'(busy),      0);
    check("t6_done",  int'(done),      0);
    check("t6_addr",  int'(rom_addr),  0);
    check("t6_data",  int'(out_data),  0);
    repeat (4) begin
      @(negedge clk);
      check("t6_no_done", int'(done), 0);
    end
    begin_burst(9, 2);
    collect(40, 1'b0);
    check("t6_n",  got.size(), 2);
    check("t6_f0", gw(0), 'h19);
    check("t6_f1", gw(1), 'h1A);

    repeat (2) @(negedge clk);
    check("model_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
